// File: rtl/score_argmax_pkg.sv
// Shared constants and types for the argmax reader on the vector-matrix product output.
package score_argmax_pkg;

   localparam int N          = 10;
   localparam int VALUE_SIZE = 26;
   localparam int IDX_W      = 4;

   typedef logic signed [VALUE_SIZE-1:0] score_t;
   typedef logic [IDX_W-1:0]             idx_t;

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

endpackage

// File: rtl/score_argmax_max_select.sv
// Running-max update: the single place holding the signed compare and the tie rule.
module score_max_select
   import score_argmax_pkg::*;
(
   input  score_t cur_max,
   input  idx_t   cur_idx,
   input  score_t score,
   input  idx_t   beat_idx,
   input  logic   first,
   output score_t nxt_max,
   output idx_t   nxt_idx
);

   // Strict greater-than: an equal score never displaces the earlier class.
   always_comb begin
      nxt_max = cur_max;
      nxt_idx = cur_idx;
      if (first || (score > cur_max)) begin
         nxt_max = score;
         nxt_idx = beat_idx;
      end
   end

endmodule

// File: rtl/score_argmax.sv
// Serial argmax over N signed class scores, result presented on a valid/ready port.
module score_argmax
   import score_argmax_pkg::*;
(
   input  logic   clk,
   input  logic   GlobalReset,
   input  logic   score_valid,
   output logic   score_ready,
   input  score_t score_value,
   input  logic   score_last,
   output logic   class_valid,
   input  logic   class_ready,
   output idx_t   class_index,
   output score_t class_score,
   output logic   class_error
);

   state_t state, state_next;
   idx_t   count;
   score_t max_score, nxt_max;
   idx_t   max_idx, nxt_idx;
   logic   accept, count_full, frame_end;

   assign score_ready = (state == ACCUM);
   assign class_valid = (state == HOLD);
   assign accept      = score_valid && score_ready;
   assign count_full  = (count == idx_t'(N - 1));
   assign frame_end   = accept && (score_last || count_full);

   score_max_select u_sel (
      .cur_max  (max_score),
      .cur_idx  (max_idx),
      .score    (score_value),
      .beat_idx (count),
      .first    (count == '0),
      .nxt_max  (nxt_max),
      .nxt_idx  (nxt_idx)
   );

   always_ff @(posedge clk or negedge GlobalReset) begin
      if (!GlobalReset) begin
         state <= ACCUM;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ACCUM: if (frame_end)   state_next = HOLD;
         HOLD:  if (class_ready) state_next = ACCUM;
         default:                state_next = ACCUM;
      endcase
   end

   always_ff @(posedge clk or negedge GlobalReset) begin
      if (!GlobalReset) begin
         count       <= '0;
         max_score   <= '0;
         max_idx     <= '0;
         class_index <= '0;
         class_score <= '0;
         class_error <= 1'b0;
      end else if (accept) begin
         max_score <= nxt_max;
         max_idx   <= nxt_idx;
         if (frame_end) begin
            // Result takes the max including the terminating beat.
            class_index <= nxt_idx;
            class_score <= nxt_max;
            class_error <= score_last ^ count_full;
            count       <= '0;
         end else begin
            count <= count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_score_argmax.sv
// Directed bench for score_argmax with hand-computed expected results.
module tb_score_argmax;
   import score_argmax_pkg::*;

   logic   clk = 1'b0;
   logic   GlobalReset;
   logic   score_valid, score_ready, score_last;
   score_t score_value;
   logic   class_valid, class_ready, class_error;
   idx_t   class_index;
   score_t class_score;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   score_argmax dut (
      .clk         (clk),
      .GlobalReset (GlobalReset),
      .score_valid (score_valid),
      .score_ready (score_ready),
      .score_value (score_value),
      .score_last  (score_last),
      .class_valid (class_valid),
      .class_ready (class_ready),
      .class_index (class_index),
      .class_score (class_score),
      .class_error (class_error)
   );

   task automatic check(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic send(input int v, input logic l);
      int cyc = 0;
      score_valid = 1'b1;
      score_value = score_t'(v);
      score_last  = l;
      while (!score_ready && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      if (cyc >= 50) check("send_timeout", 0, 1);
      @(negedge clk);
      score_valid = 1'b0;
   endtask

   task automatic check_result(input string tag, input int idx, input int sc, input int err);
      int cyc = 0;
      while (!class_valid && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      check({tag, "_valid"}, class_valid, 1);
      check({tag, "_index"}, class_index, idx);
      check({tag, "_score"}, class_score, sc);
      check({tag, "_error"}, class_error, err);
   endtask

   task automatic take_result();
      class_ready = 1'b1;
      @(negedge clk);
      class_ready = 1'b0;
      check("handshake_valid_low", class_valid, 0);
      check("handshake_ready_high", score_ready, 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int f1 [10] = '{5, -3, 100, 7, 100, 0, -1, 2, 9, 99};
      int f3 [10] = '{-5, -7, -1, -9, -1, -3, -2, -8, -4, -6};
      logic [IDX_W-1:0] held_idx;
      logic signed [31:0] held_score;
      int tb_beat, results, prev_cyc;

      GlobalReset = 1'b0;
      score_valid = 1'b0;
      score_value = '0;
      score_last  = 1'b0;
      class_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_score_ready", score_ready, 1);
      check("rst_class_valid", class_valid, 0);
      check("rst_class_index", class_index, 0);
      check("rst_class_score", class_score, 0);
      check("rst_class_error", class_error, 0);
      GlobalReset = 1'b1;
      @(negedge clk);

      // Frame 1: max 100 at 2, tie at 4 ignored; valid rises right after beat 9
      for (int k = 0; k < 10; k++) begin
         if (k == 9) check("f1_valid_before_last", class_valid, 0);
         send(f1[k], k == 9);
      end
      check("f1_latency", class_valid, 1);
      check_result("f1", 2, 100, 0);
      take_result();

      // All scores at most-negative value
      for (int k = 0; k < 10; k++) send(-33554432, k == 9);
      check_result("neg", 0, -33554432, 0);
      take_result();

      // Short frame
      for (int k = 0; k < 4; k++) send(k + 1, k == 3);
      check_result("short", 3, 4, 1);
      take_result();

      // Ten beats, no last
      for (int k = 0; k < 10; k++) send(f3[k], 1'b0);
      check_result("nolast", 2, -1, 1);

      // Stall in HOLD with a beat offered
      held_idx    = class_index;
      held_score  = class_score;
      score_valid = 1'b1;
      score_value = score_t'(777);
      score_last  = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("hold_ready_low", score_ready, 0);
         check("hold_valid", class_valid, 1);
         check("hold_index_stable", class_index, held_idx);
         check("hold_score_stable", class_score, held_score);
      end
      score_valid = 1'b0;
      take_result();
      send(3, 1'b0); send(8, 1'b0); send(8, 1'b0); send(1, 1'b1);
      check_result("after_hold", 1, 8, 1);
      take_result();

      // Back-to-back frames, valid and ready tied high
      class_ready = 1'b1;
      score_valid = 1'b1;
      tb_beat = 0; results = 0; prev_cyc = -1;
      for (int cyc = 0; cyc < 80 && results < 3; cyc++) begin
         if (class_valid) begin
            check("b2b_index", class_index, results + 3);
            check("b2b_score", class_score, 1000 + results);
            check("b2b_error", class_error, 0);
            if (prev_cyc >= 0) check("b2b_period", cyc - prev_cyc, 11);
            prev_cyc = cyc;
            results++;
         end
         if (score_ready) begin
            score_value = score_t'(((tb_beat % 10) == (tb_beat / 10) + 3)
                                   ? 1000 + tb_beat / 10 : tb_beat % 10);
            score_last  = (tb_beat % 10) == 9;
            tb_beat++;
         end
         @(negedge clk);
      end
      check("b2b_results", results, 3);
      score_valid = 1'b0;
      class_ready = 1'b0;
      repeat (2) @(negedge clk);

      // Reset mid-frame discards partial data
      for (int k = 0; k < 5; k++) send(k == 1 ? 5000 : 0, 1'b0);
      GlobalReset = 1'b0;
      @(negedge clk);
      check("mid_rst_score_ready", score_ready, 1);
      check("mid_rst_class_valid", class_valid, 0);
      check("mid_rst_class_score", class_score, 0);
      check("mid_rst_class_index", class_index, 0);
      GlobalReset = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 10; k++) send(k + 1, k == 9);
      check_result("post_rst", 9, 10, 0);
      take_result();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
